// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: queues MEM-stage load/store requests and issues them one at a time
// to mem_system, returning data/hit/error and keeping saturating perf counters.
module mem_req_sequencer #(
   parameter int QDEPTH  = 2,
   parameter int TIMEOUT = 31,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic             req_wr,
   input  logic [15:0]      req_addr,
   input  logic [15:0]      req_wdata,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic [15:0]      rsp_rdata,
   output logic             rsp_hit,
   output logic             rsp_err,
   output logic [15:0]      Addr,
   output logic [15:0]      DataIn,
   output logic             Rd,
   output logic             Wr,
   input  logic [15:0]      DataOut,
   input  logic             Done,
   input  logic             Stall,
   input  logic             CacheHit,
   output logic [CNT_W-1:0] perf_req,
   output logic [CNT_W-1:0] perf_hit
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t          r_st, w_nxt;
   logic            r_q_wr    [QDEPTH];
   logic [15:0]     r_q_addr  [QDEPTH];
   logic [15:0]     r_q_wdata [QDEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_tmr;
   logic            w_push, w_pop, w_issue, w_rsp, w_err, w_done, w_empty, w_h_al;
   assign req_ready = r_cnt != CW'(QDEPTH);
   assign w_push    = req_valid & req_ready;
   assign w_empty   = r_cnt == '0;
   assign w_h_al    = !w_empty && !r_q_addr[r_rp][0];
   always_comb begin
      w_nxt   = r_st;
      w_pop   = 1'b0;
      w_issue = 1'b0;
      w_rsp   = 1'b0;
      w_err   = 1'b0;
      w_done  = 1'b0;
      case (r_st)
         IDLE: if (!w_empty && !Stall) begin
            w_pop   = 1'b1;
            w_issue = w_h_al;
            w_rsp   = !w_h_al;
            w_err   = !w_h_al;
            w_nxt   = w_h_al ? BUSY : IDLE;
         end
         BUSY: if (Done) begin
            w_done  = 1'b1;
            w_rsp   = 1'b1;
            w_issue = w_h_al;
            w_pop   = w_h_al;
            w_nxt   = w_h_al ? BUSY : IDLE;
         end else if (r_tmr == 8'(TIMEOUT - 1)) begin
            w_rsp = 1'b1;
            w_err = 1'b1;
            w_nxt = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_wr[r_wp]    <= req_wr;
         r_q_addr[r_wp]  <= req_addr;
         r_q_wdata[r_wp] <= req_wdata;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_push);
         r_rp  <= r_rp + AW'(w_pop);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st      <= IDLE;
         r_tmr     <= '0;
         Addr      <= '0;
         DataIn    <= '0;
         Rd        <= 1'b0;
         Wr        <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_hit   <= 1'b0;
         rsp_err   <= 1'b0;
         perf_req  <= '0;
         perf_hit  <= '0;
      end else begin
         r_st      <= w_nxt;
         rsp_valid <= w_rsp;
         if (w_issue) begin
            Addr   <= r_q_addr[r_rp];
            DataIn <= r_q_wdata[r_rp];
            Rd     <= !r_q_wr[r_rp];
            Wr     <= r_q_wr[r_rp];
            r_tmr  <= '0;
         end else if (r_st == BUSY && w_nxt == IDLE) begin
            Rd <= 1'b0;
            Wr <= 1'b0;
         end else if (r_st == BUSY) begin
            r_tmr <= r_tmr + 8'd1;
         end
         // Rd still reflects the completing request here, so stores return zero data
         if (w_rsp) begin
            rsp_rdata <= (w_done && Rd) ? DataOut : '0;
            rsp_hit   <= w_done & CacheHit;
            rsp_err   <= w_err;
         end
         if (w_issue && perf_req != '1) perf_req <= perf_req + CNT_W'(1);
         if (w_done && CacheHit && perf_hit != '1) perf_hit <= perf_hit + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: directed bench with a response scoreboard checked on every rsp_valid pulse.
module tb_mem_req_sequencer;
   logic        clk, rst_n;
   logic        req_valid, req_wr, req_ready;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_hit, rsp_err;
   logic [15:0] rsp_rdata, Addr, DataIn, DataOut;
   logic        Rd, Wr, Done, Stall, CacheHit;
   logic [15:0] perf_req, perf_hit;
   logic [17:0] sb [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_cyc;
   mem_req_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
      .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .DataOut(DataOut), .Done(Done),
      .Stall(Stall), .CacheHit(CacheHit), .perf_req(perf_req), .perf_hit(perf_hit)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_exp(input logic [15:0] d, input logic h, input logic e);
      sb.push_back({d, h, e});
   endtask
   task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] wd);
      int n = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = wd;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("send_ready_timeout", {31'b0, req_ready}, 1);
      tick();
      req_valid = 1'b0;
   endtask
   // holds the current request for n cycles checking the interface, then returns Done
   task automatic mem_done(input int n, input logic [15:0] a, input logic [15:0] wd,
                           input logic wr, input logic [15:0] d, input logic h);
      for (int i = 0; i < n; i++) begin
         chk("hold_addr", Addr, a);
         chk("hold_din", DataIn, wd);
         chk("hold_rd", Rd, !wr);
         chk("hold_wr", Wr, wr);
         if (i == n - 1) begin
            Done     = 1'b1;
            DataOut  = d;
            CacheHit = h;
         end
         tick();
      end
      Done     = 1'b0;
      CacheHit = 1'b0;
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         chk("rd_wr_excl", {31'b0, Rd & Wr}, 0);
         if (rsp_valid) begin
            if (sb.size() == 0) chk("rsp_extra", {31'b0, rsp_valid}, 0);
            else begin
               logic [17:0] e;
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e[17:2]);
               chk("rsp_hit", rsp_hit, e[1]);
               chk("rsp_err", rsp_err, e[0]);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      DataOut = '0; Done = 1'b0; Stall = 1'b0; CacheHit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rd", Rd, 0);
      chk("rst_wr", Wr, 0);
      chk("rst_perf_req", perf_req, 0);
      chk("rst_perf_hit", perf_hit, 0);
      rst_n = 1'b1;
      tick();
      // load hit, Done on the second busy cycle
      push_exp(16'hBEEF, 1, 0);
      send(0, 16'h0010, 0);
      chk("t1_not_yet", Rd, 0);
      tick();
      mem_done(2, 16'h0010, 0, 0, 16'hBEEF, 1);
      chk("t1_rd_drop", Rd, 0);
      chk("t1_rsp_pulse", rsp_valid, 1);
      chk("t1_perf_req", perf_req, 1);
      chk("t1_perf_hit", perf_hit, 1);
      tick();
      chk("t1_rsp_end", rsp_valid, 0);
      chk("t1_rdata_hold", rsp_rdata, 16'hBEEF);
      // store miss with Stall high for 12 cycles
      push_exp(16'h0000, 0, 0);
      send(1, 16'h0020, 16'h1234);
      tick();
      Stall = 1'b1;
      mem_done(12, 16'h0020, 16'h1234, 1, 16'hDEAD, 0);
      Stall = 1'b0;
      chk("t2_wr_drop", Wr, 0);
      chk("t2_perf_req", perf_req, 2);
      chk("t2_perf_hit", perf_hit, 1);
      tick();
      // three loads against a 2-deep FIFO
      push_exp(16'hA001, 1, 0);
      push_exp(16'hA002, 0, 0);
      push_exp(16'hA003, 1, 0);
      Stall = 1'b1;
      req_valid = 1'b1; req_wr = 1'b0; req_wdata = '0; req_addr = 16'h0040;
      tick();
      req_addr = 16'h0042;
      tick();
      req_addr = 16'h0044;
      chk("t3_full", req_ready, 0);
      tick();
      chk("t3_full_hold", req_ready, 0);
      Stall = 1'b0;
      chk("t3_prepop", req_ready, 0);
      tick();
      chk("t3_issue_rd", Rd, 1);
      chk("t3_issue_addr", Addr, 16'h0040);
      chk("t3_ready_after_pop", req_ready, 1);
      tick();
      req_valid = 1'b0;
      mem_done(4, 16'h0040, 0, 0, 16'hA001, 1);
      mem_done(2, 16'h0042, 0, 0, 16'hA002, 0);
      mem_done(1, 16'h0044, 0, 0, 16'hA003, 1);
      chk("t3_idle_rd", Rd, 0);
      chk("t3_perf_req", perf_req, 5);
      chk("t3_perf_hit", perf_hit, 3);
      tick();
      // misaligned load followed by a normal one
      push_exp(16'h0000, 0, 1);
      push_exp(16'hC001, 1, 0);
      send(0, 16'h0013, 0);
      send(0, 16'h0050, 0);
      chk("t4_no_rd", Rd, 0);
      chk("t4_err_pulse", rsp_valid, 1);
      chk("t4_perf_req", perf_req, 5);
      tick();
      mem_done(3, 16'h0050, 0, 0, 16'hC001, 1);
      chk("t4_perf_req_next", perf_req, 6);
      tick();
      // timeout, then a stray Done
      push_exp(16'h0000, 0, 1);
      send(0, 16'h0060, 0);
      tick();
      n_cyc = 0;
      while (Rd && n_cyc < 40) begin
         n_cyc++;
         tick();
      end
      chk("t5_rd_cycles", n_cyc, 31);
      chk("t5_to_pulse", rsp_valid, 1);
      tick();
      Done = 1'b1; CacheHit = 1'b1; DataOut = 16'h5555;
      tick();
      Done = 1'b0; CacheHit = 1'b0;
      repeat (3) tick();
      chk("t5_perf_req", perf_req, 7);
      chk("t5_perf_hit", perf_hit, 4);
      // async reset while busy
      send(0, 16'h0070, 0);
      tick();
      chk("t6_busy", Rd, 1);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rd", Rd, 0);
      chk("t6_wr", Wr, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_ready", req_ready, 1);
      chk("t6_perf_req", perf_req, 0);
      chk("t6_perf_hit", perf_hit, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      push_exp(16'h7777, 0, 0);
      send(0, 16'h0080, 0);
      tick();
      mem_done(1, 16'h0080, 0, 0, 16'h7777, 0);
      chk("t6_recover_req", perf_req, 1);
      chk("t6_recover_hit", perf_hit, 0);
      repeat (2) tick();
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
